// File: rtl/ram_pkg.sv
// Shared constants for the parametrised RAM: read-during-write mode codes and
// the clear-sequencer state encoding.
package ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_param_if.sv
// Access bus of the parametrised RAM: clear request, byte-enabled write,
// read request and the read-data return path.
interface ram_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic                  i_clr;
    logic                  o_busy;
    logic                  i_we;
    logic [DATA_W/8-1:0]   i_be;
    logic                  i_re;
    logic [ADDR_W-1:0]     i_rwaddr;
    logic [DATA_W-1:0]     i_di;
    logic [DATA_W-1:0]     o_do;
    logic                  o_dvalid;

    modport master (
        output i_clr, i_we, i_be, i_re, i_rwaddr, i_di,
        input  o_busy, o_do, o_dvalid
    );

    modport slave (
        input  i_clr, i_we, i_be, i_re, i_rwaddr, i_di,
        output o_busy, o_do, o_dvalid
    );

endinterface

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every address once after reset or on request,
// holding the RAM busy until the last word has been written.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    // FSM and address counter; busy is registered alongside the state
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == {ADDR_W{1'b1}}) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (i_clr) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, optional output register and clear sequencer.
module ram_param
    import ram_pkg::*;
#(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 6,
    parameter int              RDW_MODE  = 0,
    parameter int              OUT_REG   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    ram_param_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W / 8;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("ram_param: DATA_W must be a multiple of 8");
    end

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_user_ok;
    logic              w_user_we;
    logic              w_user_re;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    ram_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (bus.i_clr),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign bus.o_busy = w_busy;

    // User accesses are dropped while clearing and in the cycle a clear starts.
    assign w_user_ok = !w_busy && !bus.i_clr;
    assign w_user_we = w_user_ok && bus.i_we;
    assign w_user_re = w_user_ok && bus.i_re;
    assign w_old     = r_mem[bus.i_rwaddr];

    // Word as it will look after this cycle's write (old bytes where be=0)
    // NOTE: a default assignment before the loop keeps this purely
    // combinational; without it unselected bytes would infer latches.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (bus.i_be[i]) begin
                w_merged[8*i +: 8] = bus.i_di[8*i +: 8];
            end
        end
    end

    // Array write port, shared between the clear sequencer and the user
    // NOTE: the array has no reset so it maps onto block RAM; known content
    // comes from the clear sequencer instead.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= CLEAR_VAL;
        end else if (w_user_we) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.i_be[i]) begin
                    r_mem[bus.i_rwaddr][8*i +: 8] <= bus.i_di[8*i +: 8];
                end
            end
        end
    end

    // First read stage with read-during-write selection; data holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_user_re) begin
            if (w_user_we && RDW_MODE == RDW_NO_CHANGE) begin
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= (w_user_we && RDW_MODE == RDW_WRITE_FIRST) ? w_merged : w_old;
            end
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] r_out_data;
        logic              r_out_valid;

        // Optional output pipeline stage; only valid reads update the data
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_rd_valid;
                if (r_rd_valid) begin
                    r_out_data <= r_rd_data;
                end
            end
        end

        assign bus.o_do     = r_out_data;
        assign bus.o_dvalid = r_out_valid;
    end else begin : g_no_out_reg
        assign bus.o_do     = r_rd_data;
        assign bus.o_dvalid = r_rd_valid;
    end

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: five instances (three read-during-write modes,
// output register, non-zero clear value) share one stimulus stream.
module tb_ram_param;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        we;
    logic        re;
    logic [1:0]  be;
    logic [5:0]  addr;
    logic [15:0] di;

    int errors = 0;
    int checks = 0;

    ram_param_if #(.DATA_W(16), .ADDR_W(6)) if_wf ();
    ram_param_if #(.DATA_W(16), .ADDR_W(6)) if_rf ();
    ram_param_if #(.DATA_W(16), .ADDR_W(6)) if_nc ();
    ram_param_if #(.DATA_W(16), .ADDR_W(6)) if_or ();
    ram_param_if #(.DATA_W(16), .ADDR_W(6)) if_cv ();

    assign if_wf.i_clr = clr, if_wf.i_we = we, if_wf.i_re = re, if_wf.i_be = be, if_wf.i_rwaddr = addr, if_wf.i_di = di;
    assign if_rf.i_clr = clr, if_rf.i_we = we, if_rf.i_re = re, if_rf.i_be = be, if_rf.i_rwaddr = addr, if_rf.i_di = di;
    assign if_nc.i_clr = clr, if_nc.i_we = we, if_nc.i_re = re, if_nc.i_be = be, if_nc.i_rwaddr = addr, if_nc.i_di = di;
    assign if_or.i_clr = clr, if_or.i_we = we, if_or.i_re = re, if_or.i_be = be, if_or.i_rwaddr = addr, if_or.i_di = di;
    assign if_cv.i_clr = clr, if_cv.i_we = we, if_cv.i_re = re, if_cv.i_be = be, if_cv.i_rwaddr = addr, if_cv.i_di = di;

    ram_param #(.RDW_MODE(0))             u_wf (.clk(clk), .rst(rst), .bus(if_wf));
    ram_param #(.RDW_MODE(1))             u_rf (.clk(clk), .rst(rst), .bus(if_rf));
    ram_param #(.RDW_MODE(2))             u_nc (.clk(clk), .rst(rst), .bus(if_nc));
    ram_param #(.OUT_REG(1))              u_or (.clk(clk), .rst(rst), .bus(if_or));
    ram_param #(.CLEAR_VAL(16'hA5A5))     u_cv (.clk(clk), .rst(rst), .bus(if_cv));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        tick();
        tick();
        checks++; if (if_wf.o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", if_wf.o_busy); end
        checks++; if (if_wf.o_do !== 16'h0000) begin errors++; $display("FAIL reset_do: got %h want 0000", if_wf.o_do); end
        checks++; if (if_wf.o_dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b want 0", if_wf.o_dvalid); end
        checks++; if (if_or.o_do !== 16'h0000) begin errors++; $display("FAIL reset_do_outreg: got %h want 0000", if_or.o_do); end
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (if_wf.o_busy === 1'b1 && n < 200);
        checks++; if (n !== 64) begin errors++; $display("FAIL init_clear_len: got %0d cycles want 64", n); end
        checks++; if (if_cv.o_busy !== 1'b0) begin errors++; $display("FAIL init_clear_cv_busy: got %b want 0", if_cv.o_busy); end
        addr = 6'h3F; re = 1'b1;
        tick();
        re = 1'b0;
        checks++; if (if_wf.o_do !== 16'h0000 || if_wf.o_dvalid !== 1'b1) begin errors++; $display("FAIL read_3f: got %h/%b want 0000/1", if_wf.o_do, if_wf.o_dvalid); end
        checks++; if (if_cv.o_do !== 16'hA5A5) begin errors++; $display("FAIL read_3f_cv: got %h want a5a5", if_cv.o_do); end
        checks++; if (if_or.o_dvalid !== 1'b0) begin errors++; $display("FAIL outreg_early: got dvalid %b want 0", if_or.o_dvalid); end
        tick();
        checks++; if (if_or.o_do !== 16'h0000 || if_or.o_dvalid !== 1'b1) begin errors++; $display("FAIL outreg_lat2: got %h/%b want 0000/1", if_or.o_do, if_or.o_dvalid); end
        checks++; if (if_wf.o_dvalid !== 1'b0) begin errors++; $display("FAIL dvalid_pulse: got %b want 0", if_wf.o_dvalid); end
    endtask

    task automatic test_read_write();
        we = 1'b1; be = 2'b11; addr = 6'h2A; di = 16'hCAFE;
        tick();
        we = 1'b0; re = 1'b1;
        tick();
        checks++; if (if_wf.o_do !== 16'hCAFE || if_wf.o_dvalid !== 1'b1) begin errors++; $display("FAIL read_2a: got %h/%b want cafe/1", if_wf.o_do, if_wf.o_dvalid); end
        addr = 6'h3A;
        tick();
        checks++; if (if_wf.o_do !== 16'h0000 || if_wf.o_dvalid !== 1'b1) begin errors++; $display("FAIL read_3a: got %h/%b want 0000/1", if_wf.o_do, if_wf.o_dvalid); end
        re = 1'b0; addr = 6'h2A;
        tick();
        tick();
        checks++; if (if_wf.o_do !== 16'h0000 || if_wf.o_dvalid !== 1'b0) begin errors++; $display("FAIL re0_hold: got %h/%b want 0000/0", if_wf.o_do, if_wf.o_dvalid); end
    endtask

    task automatic test_byte_enable();
        we = 1'b1; be = 2'b01; addr = 6'h2A; di = 16'h1234;
        tick();
        we = 1'b0; re = 1'b1;
        tick();
        re = 1'b0;
        checks++; if (if_wf.o_do !== 16'hCA34) begin errors++; $display("FAIL be_low: got %h want ca34", if_wf.o_do); end
        we = 1'b1; be = 2'b00; di = 16'hFFFF;
        tick();
        we = 1'b0; re = 1'b1;
        tick();
        re = 1'b0;
        checks++; if (if_wf.o_do !== 16'hCA34 || if_wf.o_dvalid !== 1'b1) begin errors++; $display("FAIL be_none: got %h/%b want ca34/1", if_wf.o_do, if_wf.o_dvalid); end
    endtask

    task automatic test_rdw();
        we = 1'b1; re = 1'b1; be = 2'b11; addr = 6'h3A; di = 16'hDEED;
        tick();
        we = 1'b0; re = 1'b0;
        checks++; if (if_wf.o_do !== 16'hDEED || if_wf.o_dvalid !== 1'b1) begin errors++; $display("FAIL rdw_write_first: got %h/%b want deed/1", if_wf.o_do, if_wf.o_dvalid); end
        checks++; if (if_rf.o_do !== 16'h0000 || if_rf.o_dvalid !== 1'b1) begin errors++; $display("FAIL rdw_read_first: got %h/%b want 0000/1", if_rf.o_do, if_rf.o_dvalid); end
        checks++; if (if_nc.o_do !== 16'hCA34 || if_nc.o_dvalid !== 1'b0) begin errors++; $display("FAIL rdw_no_change: got %h/%b want ca34/0", if_nc.o_do, if_nc.o_dvalid); end
        re = 1'b1;
        tick();
        re = 1'b0;
        checks++; if (if_wf.o_do !== 16'hDEED) begin errors++; $display("FAIL rdw_after_wf: got %h want deed", if_wf.o_do); end
        checks++; if (if_rf.o_do !== 16'hDEED) begin errors++; $display("FAIL rdw_after_rf: got %h want deed", if_rf.o_do); end
        checks++; if (if_nc.o_do !== 16'hDEED) begin errors++; $display("FAIL rdw_after_nc: got %h want deed", if_nc.o_do); end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; be = 2'b11; addr = 6'h2A; di = 16'hCAFE;
        tick();
        we = 1'b0; re = 1'b1;
        tick();
        checks++; if (if_or.o_dvalid !== 1'b0) begin errors++; $display("FAIL b2b_first_edge: got dvalid %b want 0", if_or.o_dvalid); end
        addr = 6'h3A;
        tick();
        re = 1'b0;
        checks++; if (if_or.o_do !== 16'hCAFE || if_or.o_dvalid !== 1'b1) begin errors++; $display("FAIL b2b_word0: got %h/%b want cafe/1", if_or.o_do, if_or.o_dvalid); end
        tick();
        checks++; if (if_or.o_do !== 16'hDEED || if_or.o_dvalid !== 1'b1) begin errors++; $display("FAIL b2b_word1: got %h/%b want deed/1", if_or.o_do, if_or.o_dvalid); end
        tick();
        checks++; if (if_or.o_do !== 16'hDEED || if_or.o_dvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %h/%b want deed/0", if_or.o_do, if_or.o_dvalid); end
    endtask

    task automatic test_clear();
        int n;
        int dv_bad;
        clr = 1'b1; we = 1'b1; re = 1'b1; be = 2'b11; addr = 6'h10; di = 16'h1111;
        tick();
        clr = 1'b0; addr = 6'h05; di = 16'h5555;
        checks++; if (if_cv.o_busy !== 1'b1 || if_cv.o_dvalid !== 1'b0) begin errors++; $display("FAIL clr_start: got busy/dvalid %b/%b want 1/0", if_cv.o_busy, if_cv.o_dvalid); end
        n = 0;
        dv_bad = 0;
        do begin
            tick();
            n++;
            if (if_cv.o_dvalid !== 1'b0) dv_bad++;
        end while (if_cv.o_busy === 1'b1 && n < 200);
        we = 1'b0; re = 1'b0;
        checks++; if (n !== 64) begin errors++; $display("FAIL clr_len: got %0d cycles want 64", n); end
        checks++; if (dv_bad !== 0) begin errors++; $display("FAIL clr_dvalid: got %0d valid cycles want 0", dv_bad); end
        re = 1'b1;
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a);
            tick();
            checks++; if (if_cv.o_do !== 16'hA5A5) begin errors++; $display("FAIL clr_word_cv[%0d]: got %h want a5a5", a, if_cv.o_do); end
            checks++; if (if_wf.o_do !== 16'h0000) begin errors++; $display("FAIL clr_word_wf[%0d]: got %h want 0000", a, if_wf.o_do); end
        end
        re = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (if_cv.o_busy !== 1'b1 || if_cv.o_do !== 16'h0000 || if_cv.o_dvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_flush: got busy/do/dvalid %b/%h/%b want 1/0000/0", if_cv.o_busy, if_cv.o_do, if_cv.o_dvalid); end
        tick();
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (if_cv.o_busy === 1'b1 && n < 200);
        checks++; if (n !== 64) begin errors++; $display("FAIL mid_rst_clear_len: got %0d cycles want 64", n); end
        addr = 6'h30; re = 1'b1;
        tick();
        re = 1'b0;
        checks++; if (if_cv.o_do !== 16'hA5A5 || if_cv.o_dvalid !== 1'b1) begin errors++; $display("FAIL mid_rst_read: got %h/%b want a5a5/1", if_cv.o_do, if_cv.o_dvalid); end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        be = 2'b00; addr = 6'h00; di = 16'h0000;
        test_reset();
        test_read_write();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
